// File: rtl/mc_controller_p.sv
// Multi-cycle CPU control FSM: decodes the IR and flags into datapath mux selects and
// write enables, with a memory-ready handshake and a sticky illegal-opcode trap.
module mc_controller_p #(
   parameter int IW            = 24,
   parameter int ALU_W         = 3,
   parameter int MEM_HANDSHAKE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IW-1:0]    IRout,
   input  logic [3:0]       flag,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             AdrSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic [2:0]       RegSrc,
   output logic [ALU_W-1:0] ALUControl,
   output logic             mem_req,
   output logic             illegal,
   output logic [3:0]       state_o
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC_R  = 4'd2,
      S_EXEC_I  = 4'd3,
      S_ALU_WB  = 4'd4,
      S_MEM_ADR = 4'd5,
      S_MEM_RD  = 4'd6,
      S_MEM_WB  = 4'd7,
      S_MEM_WR  = 4'd8,
      S_BR_LINK = 4'd9,
      S_BR_PC   = 4'd10,
      S_ILLEGAL = 4'd11
   } state_t;

   typedef struct packed {
      logic             pc_write;
      logic             mem_write;
      logic             reg_write;
      logic             adr_src;
      logic             alu_src_a;
      logic [1:0]       alu_src_b;
      logic [1:0]       result_src;
      logic [2:0]       reg_src;
      logic [ALU_W-1:0] alu_control;
      logic             mem_req;
      logic             illegal;
   } ctl_t;

   // Moore output table: outputs for a state given the latched decode fields.
   function automatic ctl_t ctl_of(input state_t s, input logic shift, input logic store,
                                   input logic [ALU_W-1:0] fn);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req    = 1'b1;
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_DECODE: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_EXEC_R: begin
            c.alu_src_b   = 2'b00;
            c.alu_control = fn;
         end
         S_EXEC_I: begin
            c.alu_src_b   = shift ? 2'b11 : 2'b01;
            c.alu_control = fn;
         end
         S_ALU_WB: begin
            c.reg_write  = 1'b1;
            c.result_src = 2'b00;
         end
         S_MEM_ADR: begin
            c.alu_control = '0;
            c.alu_src_b   = store ? 2'b01 : 2'b11;
            c.reg_src     = store ? 3'b010 : 3'b000;
         end
         S_MEM_RD: begin
            c.adr_src = 1'b1;
            c.mem_req = 1'b1;
         end
         S_MEM_WB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            c.adr_src   = 1'b1;
            c.mem_req   = 1'b1;
            c.mem_write = 1'b1;
            c.reg_src   = 3'b010;
         end
         S_BR_LINK: begin
            c.reg_write  = 1'b1;
            c.result_src = 2'b10;
            c.reg_src    = 3'b111;
         end
         S_BR_PC: begin
            c.alu_src_a  = 1'b0;
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.reg_src    = 3'b011;
            c.pc_write   = 1'b1;
         end
         S_ILLEGAL: c.illegal = 1'b1;
         default:   c = '0;
      endcase
      return c;
   endfunction

   logic             lnk_s;
   logic [1:0]       cls_s;
   logic [1:0]       sub_s;
   logic             imm_s;
   logic [ALU_W-1:0] func_s;
   logic             rdy_s;
   logic             eq_take_s;
   logic             unused_bits_s;

   assign lnk_s         = IRout[IW-1];
   assign cls_s         = IRout[IW-2 -: 2];
   assign sub_s         = IRout[IW-4 -: 2];
   assign imm_s         = IRout[IW-6];
   assign func_s        = IRout[IW-7 -: ALU_W];
   assign rdy_s         = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign eq_take_s     = lnk_s ? ~flag[0] : flag[0];
   assign unused_bits_s = ^{IRout[IW-7-ALU_W:0], flag[2:1]};

   state_t           state_r, nxt_state_s;
   logic [ALU_W-1:0] func_r, nxt_func_s;
   logic             shift_r, nxt_shift_s;
   logic             store_r, nxt_store_s;
   ctl_t             ctl_r, ctl_s;

   // Next-state and decode-field latch selection; flags only matter in DECODE.
   always_comb begin
      nxt_state_s = state_r;
      nxt_func_s  = func_r;
      nxt_shift_s = shift_r;
      nxt_store_s = store_r;
      case (state_r)
         S_FETCH:  nxt_state_s = rdy_s ? S_DECODE : S_FETCH;
         S_DECODE: begin
            nxt_func_s  = func_s;
            nxt_shift_s = (cls_s == 2'b11);
            nxt_store_s = 1'b0;
            case (cls_s)
               2'b00: nxt_state_s = imm_s ? S_EXEC_I : S_EXEC_R;
               2'b11: nxt_state_s = S_EXEC_I;
               2'b01: begin
                  if (sub_s == 2'b01 && !imm_s) begin
                     nxt_state_s = S_MEM_ADR;
                  end else if (sub_s == 2'b10) begin
                     nxt_state_s = S_MEM_ADR;
                     nxt_store_s = 1'b1;
                  end else begin
                     nxt_state_s = S_ILLEGAL;
                  end
               end
               2'b10: begin
                  case (sub_s)
                     2'b00:   nxt_state_s = eq_take_s ? S_BR_PC : S_FETCH;
                     2'b01:   nxt_state_s = S_BR_PC;
                     2'b10:   nxt_state_s = flag[3] ? S_BR_PC : S_FETCH;
                     2'b11:   nxt_state_s = S_BR_LINK;
                     default: nxt_state_s = S_ILLEGAL;
                  endcase
               end
               default: nxt_state_s = S_ILLEGAL;
            endcase
         end
         S_EXEC_R:  nxt_state_s = S_ALU_WB;
         S_EXEC_I:  nxt_state_s = S_ALU_WB;
         S_ALU_WB:  nxt_state_s = S_FETCH;
         S_MEM_ADR: nxt_state_s = store_r ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:  nxt_state_s = rdy_s ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:  nxt_state_s = S_FETCH;
         S_MEM_WR:  nxt_state_s = rdy_s ? S_FETCH : S_MEM_WR;
         S_BR_LINK: nxt_state_s = S_BR_PC;
         S_BR_PC:   nxt_state_s = S_FETCH;
         S_ILLEGAL: nxt_state_s = S_ILLEGAL;
         default:   nxt_state_s = S_ILLEGAL;
      endcase
   end

   // State, latched decode fields and output register; outputs precomputed from next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_FETCH;
         func_r  <= '0;
         shift_r <= 1'b0;
         store_r <= 1'b0;
         ctl_r   <= ctl_of(S_FETCH, 1'b0, 1'b0, '0);
      end else begin
         state_r <= nxt_state_s;
         func_r  <= nxt_func_s;
         shift_r <= nxt_shift_s;
         store_r <= nxt_store_s;
         ctl_r   <= ctl_of(nxt_state_s, nxt_shift_s, nxt_store_s, nxt_func_s);
      end
   end

   // Reset forces every output low in the same cycle it is asserted.
   assign ctl_s      = reset ? '0 : ctl_r;
   assign PCWrite    = ~reset & (ctl_r.pc_write | ((state_r == S_FETCH) & rdy_s));
   assign IRWrite    = ~reset & (state_r == S_FETCH) & rdy_s;
   assign MemWrite   = ctl_s.mem_write;
   assign RegWrite   = ctl_s.reg_write;
   assign AdrSrc     = ctl_s.adr_src;
   assign ALUSrcA    = ctl_s.alu_src_a;
   assign ALUSrcB    = ctl_s.alu_src_b;
   assign ResultSrc  = ctl_s.result_src;
   assign RegSrc     = ctl_s.reg_src;
   assign ALUControl = ctl_s.alu_control;
   assign mem_req    = ctl_s.mem_req;
   assign illegal    = ctl_s.illegal;
   assign state_o    = reset ? 4'd0 : state_r;

endmodule

// File: tb/tb_mc_controller_p.sv
// Self-checking bench for mc_controller_p: vector table with cycle/enable counts,
// hand-written corner sequences and a randomized run against a step-list model.
module tb_mc_controller_p;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] IRout;
   logic [3:0]  flag;
   logic        mem_ready;
   logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, mem_req, illegal;
   logic [1:0]  ALUSrcB, ResultSrc;
   logic [2:0]  RegSrc, ALUControl;
   logic [3:0]  state_o;

   logic        d2_pcw, d2_irw, d2_mw, d2_rw, d2_adr, d2_asa, d2_mreq, d2_ill;
   logic [1:0]  d2_asb, d2_rs;
   logic [2:0]  d2_rsrc, d2_aluc;
   logic [3:0]  d2_state;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   mc_controller_p #(.IW(24), .ALU_W(3), .MEM_HANDSHAKE(1)) dut (
      .clk(clk), .reset(reset), .IRout(IRout), .flag(flag), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .RegSrc(RegSrc), .ALUControl(ALUControl), .mem_req(mem_req), .illegal(illegal),
      .state_o(state_o)
   );

   mc_controller_p #(.IW(24), .ALU_W(3), .MEM_HANDSHAKE(0)) dut_nohs (
      .clk(clk), .reset(reset), .IRout(IRout), .flag(flag), .mem_ready(1'b0),
      .PCWrite(d2_pcw), .IRWrite(d2_irw), .MemWrite(d2_mw), .RegWrite(d2_rw),
      .AdrSrc(d2_adr), .ALUSrcA(d2_asa), .ALUSrcB(d2_asb), .ResultSrc(d2_rs),
      .RegSrc(d2_rsrc), .ALUControl(d2_aluc), .mem_req(d2_mreq), .illegal(d2_ill),
      .state_o(d2_state)
   );

   typedef struct packed {
      logic       pcw, irw, mw, rw, adr, asa;
      logic [1:0] asb, rs;
      logic [2:0] rsrc, aluc;
      logic       mreq, ill;
   } outv_t;

   outv_t got;
   assign got = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                 RegSrc, ALUControl, mem_req, illegal};

   localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXR = 2, ST_EXI = 3, ST_AWB = 4, ST_ADR = 5,
                  ST_RD = 6, ST_MWB = 7, ST_WR = 8, ST_LINK = 9, ST_BRPC = 10, ST_ILL = 11;

   // Expected outputs of one step of an instruction, straight from the behaviour table.
   function automatic outv_t exp_step(input int st, input logic rdy, input logic [2:0] fn,
                                      input bit shift, input bit store);
      outv_t e;
      e = '0;
      case (st)
         ST_FETCH:  begin e.mreq = 1'b1; e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10;
                          e.pcw = rdy; e.irw = rdy; end
         ST_DECODE: begin e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10; end
         ST_EXR:    begin e.asb = 2'b00; e.aluc = fn; end
         ST_EXI:    begin e.asb = shift ? 2'b11 : 2'b01; e.aluc = fn; end
         ST_AWB:    begin e.rw = 1'b1; end
         ST_ADR:    begin e.asb = store ? 2'b01 : 2'b11; e.rsrc = store ? 3'b010 : 3'b000; end
         ST_RD:     begin e.adr = 1'b1; e.mreq = 1'b1; end
         ST_MWB:    begin e.rs = 2'b01; e.rw = 1'b1; end
         ST_WR:     begin e.adr = 1'b1; e.mreq = 1'b1; e.mw = 1'b1; e.rsrc = 3'b010; end
         ST_LINK:   begin e.rw = 1'b1; e.rs = 2'b10; e.rsrc = 3'b111; end
         ST_BRPC:   begin e.asb = 2'b01; e.rs = 2'b10; e.rsrc = 3'b011; e.pcw = 1'b1; end
         ST_ILL:    begin e.ill = 1'b1; end
         default:   e = '0;
      endcase
      return e;
   endfunction

   function automatic logic [23:0] mk(input logic lnk, input logic [1:0] cls, input logic [1:0] sub,
                                      input logic imm, input logic [2:0] fn);
      logic [14:0] lo;
      lo = 15'($urandom);
      return {lnk, cls, sub, imm, fn, lo};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      ntests++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         check("reset outputs", {14'd0, state_o, got}, 32'd0);
         tick();
      end
      reset = 1'b0;
   endtask

   // One model step; waitable steps repeat while mem_ready is low (bounded).
   task automatic one_step(input int st, input bit waitable, input logic [2:0] fn,
                           input bit shift, input bit store, input logic [23:0] ir);
      logic rdy;
      for (int w = 0; w < 8; w++) begin
         if (!waitable)  rdy = 1'($urandom);
         else if (w >= 4) rdy = 1'b1;
         else rdy = ($urandom_range(0, 3) != 0);
         mem_ready = rdy;
         #1;
         check($sformatf("model step%0d ir=%h", st, ir), got, exp_step(st, rdy, fn, shift, store));
         tick();
         if (!waitable || rdy) break;
      end
   endtask

   task automatic run_model(input logic [23:0] ir, input logic [3:0] flg);
      int         steps[$];
      logic       lnk, imm;
      logic [1:0] cls, sub;
      logic [2:0] fn;
      bit         shift, store, taken;
      lnk = ir[23]; cls = ir[22:21]; sub = ir[20:19]; imm = ir[18]; fn = ir[17:15];
      shift = (cls == 2'b11);
      store = 1'b0;
      if (cls == 2'b00) begin
         steps.push_back(imm ? ST_EXI : ST_EXR); steps.push_back(ST_AWB);
      end else if (cls == 2'b11) begin
         steps.push_back(ST_EXI); steps.push_back(ST_AWB);
      end else if (cls == 2'b01 && sub == 2'b01 && !imm) begin
         steps.push_back(ST_ADR); steps.push_back(ST_RD); steps.push_back(ST_MWB);
      end else if (cls == 2'b01 && sub == 2'b10) begin
         store = 1'b1; steps.push_back(ST_ADR); steps.push_back(ST_WR);
      end else if (cls == 2'b01) begin
         steps.push_back(ST_ILL);
      end else begin
         if (sub == 2'b11) steps.push_back(ST_LINK);
         if (sub == 2'b00)      taken = lnk ? !flg[0] : flg[0];
         else if (sub == 2'b10) taken = flg[3];
         else                   taken = 1'b1;
         if (taken) steps.push_back(ST_BRPC);
      end
      IRout = ir;
      flag  = flg;
      one_step(ST_FETCH, 1'b1, fn, shift, store, ir);
      one_step(ST_DECODE, 1'b0, fn, shift, store, ir);
      flag         = 4'($urandom);
      IRout[17:15] = 3'($urandom);
      foreach (steps[i]) begin
         if (steps[i] == ST_ILL) begin
            for (int k = 0; k < 5; k++) one_step(ST_ILL, 1'b0, fn, shift, store, ir);
            do_reset(1);
         end else begin
            one_step(steps[i], steps[i] == ST_RD || steps[i] == ST_WR, fn, shift, store, ir);
         end
      end
   endtask

   // Runs one instruction with mem_ready=1 from FETCH to the next fetch, counting enables.
   task automatic run_counted(input logic [23:0] ir, input logic [3:0] flg,
                              output int cyc, output int rw, output int pw, output int mw,
                              output int both);
      cyc = 0; rw = 0; pw = 0; mw = 0; both = 0;
      IRout = ir; flag = flg; mem_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         #1;
         if (k > 0 && IRWrite) break;
         cyc++;
         rw += int'(RegWrite); pw += int'(PCWrite); mw += int'(MemWrite);
         both += int'(RegWrite & MemWrite);
         tick();
         if (k >= 1) flag = ~flg;
      end
   endtask

   typedef struct {
      logic [23:0] ir;
      logic [3:0]  flg;
      int          cyc, rw, pw, mw;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int cyc, rw, pw, mw, both, rwm, rdc;
      reset = 1'b1; mem_ready = 1'b0; flag = 4'd0; IRout = 24'd0;
      tbl[0]  = '{mk(0, 2'b00, 2'b00, 1, 3'b010), 4'b0000, 4, 1, 1, 0};
      tbl[1]  = '{mk(0, 2'b00, 2'b01, 0, 3'b101), 4'b1111, 4, 1, 1, 0};
      tbl[2]  = '{mk(1, 2'b11, 2'b10, 0, 3'b011), 4'b0000, 4, 1, 1, 0};
      tbl[3]  = '{mk(0, 2'b01, 2'b01, 0, 3'b000), 4'b0001, 5, 1, 1, 0};
      tbl[4]  = '{mk(0, 2'b01, 2'b10, 1, 3'b000), 4'b0000, 4, 0, 1, 1};
      tbl[5]  = '{mk(0, 2'b10, 2'b00, 0, 3'b000), 4'b0001, 3, 0, 2, 0};
      tbl[6]  = '{mk(0, 2'b10, 2'b00, 0, 3'b000), 4'b0000, 2, 0, 1, 0};
      tbl[7]  = '{mk(1, 2'b10, 2'b00, 0, 3'b000), 4'b0000, 3, 0, 2, 0};
      tbl[8]  = '{mk(1, 2'b10, 2'b00, 0, 3'b000), 4'b0001, 2, 0, 1, 0};
      tbl[9]  = '{mk(0, 2'b10, 2'b01, 0, 3'b000), 4'b0000, 3, 0, 2, 0};
      tbl[10] = '{mk(0, 2'b10, 2'b10, 0, 3'b000), 4'b1000, 3, 0, 2, 0};
      tbl[11] = '{mk(0, 2'b10, 2'b10, 0, 3'b000), 4'b0111, 2, 0, 1, 0};
      tbl[12] = '{mk(0, 2'b10, 2'b11, 0, 3'b000), 4'b0000, 4, 1, 2, 0};

      #1;
      check("reset outputs async window", {14'd0, state_o, got}, 32'd0);
      tick();
      do_reset(3);

      // First cycle after reset: FETCH holds on mem_ready=0; handshake-less copy completes.
      mem_ready = 1'b0;
      #1;
      check("fetch after reset", got, exp_step(ST_FETCH, 1'b0, 3'd0, 0, 0));
      check("nohs fetch PCWrite/IRWrite/mem_req", {d2_pcw, d2_irw, d2_mreq}, 3'b111);
      tick();
      #1;
      check("fetch holds without ready", got, exp_step(ST_FETCH, 1'b0, 3'd0, 0, 0));
      tick();

      foreach (tbl[i]) begin
         run_counted(tbl[i].ir, tbl[i].flg, cyc, rw, pw, mw, both);
         check($sformatf("vec%0d cycles", i), cyc, tbl[i].cyc);
         check($sformatf("vec%0d RegWrite count", i), rw, tbl[i].rw);
         check($sformatf("vec%0d PCWrite count", i), pw, tbl[i].pw);
         check($sformatf("vec%0d MemWrite count", i), mw, tbl[i].mw);
         check($sformatf("vec%0d RegWrite&MemWrite", i), both, 0);
      end

      // LDR with two wait cycles in MEM_RD.
      IRout = mk(0, 2'b01, 2'b01, 0, 3'b110); flag = 4'd0;
      cyc = 0; rwm = 0; rw = 0; rdc = 0; mw = 0;
      for (int k = 0; k < 20; k++) begin
         mem_ready = 1'b1;
         #1;
         if (k > 0 && IRWrite) break;
         if (AdrSrc && mem_req && !MemWrite) begin
            rdc++;
            if (mw < 2) begin mem_ready = 1'b0; mw++; end
         end
         cyc++;
         rw  += int'(RegWrite);
         rwm += int'(RegWrite && ResultSrc == 2'b01);
         tick();
      end
      check("ldr wait total cycles", cyc, 7);
      check("ldr MEM_RD cycles", rdc, 3);
      check("ldr RegWrite count", rw, 1);
      check("ldr RegWrite with ResultSrc=01", rwm, 1);

      // Reset held mid-MEM_WR while memory stalls.
      IRout = mk(0, 2'b01, 2'b10, 0, 3'b000); mem_ready = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      #1;
      check("str wait MemWrite", {MemWrite, AdrSrc, mem_req, RegSrc}, 6'b111010);
      tick();
      do_reset(3);
      #1;
      check("fetch after mid-store reset", got, exp_step(ST_FETCH, 1'b0, 3'd0, 0, 0));

      // Illegal opcode is sticky until reset.
      IRout = mk(0, 2'b01, 2'b00, 0, 3'b000); mem_ready = 1'b1;
      tick(); tick();
      rw = 0; pw = 0;
      for (int k = 0; k < 8; k++) begin
         mem_ready = 1'($urandom);
         #1;
         rw += int'(illegal);
         pw += int'(PCWrite | IRWrite | RegWrite | MemWrite);
         tick();
      end
      check("illegal sticky cycles", rw, 8);
      check("illegal enables", pw, 0);
      do_reset(1);
      mem_ready = 1'b1;
      #1;
      check("fetch after illegal reset", got, exp_step(ST_FETCH, 1'b1, 3'd0, 0, 0));

      // Randomized instructions against the step-list model.
      run_model(mk(0, 2'b00, 2'b00, 1, 3'b010), 4'b0000);
      for (int n = 0; n < 150; n++) begin
         run_model(mk(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 3'($urandom)),
                   4'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/mc_controller_p.md
Name: mc_controller_p

Overview:
- Parametrised multi-cycle CPU control FSM and the successor to the fixed 24-bit controller.
- Sits between the instruction register (IR) and flag register and the datapath muxes and write enables.
- Over the previous generation it adds:
  - synchronous reset;
  - a configurable instruction/ALU-field width;
  - a memory-ready handshake that stalls fetch, load and store;
  - explicit not-taken branch handling;
  - a sticky illegal-opcode trap.
- Outputs are Moore: a function of the registered state plus latched decode fields, with mem_ready gating only where stated.

Parameters:
- IW, 24: instruction width, must be >= 9+ALU_W. Fields are MSB-relative:
  - lnk = IR[IW-1]
  - cls = IR[IW-2:IW-3]
  - sub = IR[IW-4:IW-5]
  - imm = IR[IW-6]
  - func = IR[IW-7 -: ALU_W]
- ALU_W, 3: ALU function field width.
- MEM_HANDSHAKE, 1: 1 = honour mem_ready; 0 = mem_ready is internally forced to 1.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- IRout  in  IW  current instruction register
- flag  in  4  flag[0]=Z, flag[3]=C
- mem_ready  in  1  memory completes the access this cycle
- PCWrite  out  1  PC load enable
- IRWrite  out  1  IR load enable
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register file write enable
- AdrSrc  out  1  0 = PC, 1 = ALU result address
- ALUSrcA  out  1  0 = register, 1 = PC
- ALUSrcB  out  2  00 = register, 01 = immediate, 10 = constant 4, 11 = offset/shift amount
- ResultSrc  out  2  00 = ALU, 01 = memory data, 10 = ALU result path to PC
- RegSrc  out  3  register-address select (000 normal, 010 store, 011 branch, 111 link)
- ALUControl  out  ALU_W  ALU function, 0 = ADD
- mem_req  out  1  memory access in progress
- illegal  out  1  sticky trap flag
- state_o  out  4  state encoding, for debug only

Behaviour:
- Reset:
  - While reset=1, every output is 0 and state is FETCH.
  - The first cycle after reset falls is FETCH.
  - Reset has priority in every state, including mid-stall and ILLEGAL.
- Unlisted outputs are 0 in each state.
- FETCH:
  - mem_req=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - PCWrite=IRWrite=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Latches func into func_q and samples flag into flg_q.
  - Dispatch:
    - cls=00, imm=0 -> EXEC_R
    - cls=00, imm=1 -> EXEC_I (ALUSrcB=01)
    - cls=11 (shift) -> EXEC_I (ALUSrcB=11)
    - cls=01, sub=01, imm=0 (LDR) -> MEM_ADR
    - cls=01, sub=10 (STR) -> MEM_ADR
    - cls=10, sub=00 -> BR_PC if (lnk ? !Z : Z), i.e. BEQ/BNE; else FETCH (not taken)
    - cls=10, sub=01 (B) -> BR_PC
    - cls=10, sub=10 (BCS) -> BR_PC if C, else FETCH
    - cls=10, sub=11 (BL / BL-indirect) -> BR_LINK
    - anything else -> ILLEGAL
- EXEC_R: ALUSrcB=00, ALUControl=func_q -> ALU_WB.
- EXEC_I: ALUSrcB=01 for cls=00, 11 for shift; ALUControl=func_q -> ALU_WB.
- ALU_WB: RegWrite=1, ResultSrc=00 -> FETCH.
- MEM_ADR: ALUControl=0; ALUSrcB=11 (LDR) or 01 (STR); RegSrc=010 for STR -> MEM_RD (LDR) or MEM_WR (STR).
- MEM_RD: AdrSrc=1, mem_req=1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEM_WR:
  - AdrSrc=1, mem_req=1, MemWrite=1, RegSrc=010.
  - MemWrite is held for every wait cycle; memory commits on the mem_ready cycle.
  - -> FETCH on mem_ready.
- BR_LINK: RegWrite=1, ResultSrc=10, RegSrc=111 -> BR_PC.
- BR_PC: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, RegSrc=011, PCWrite=1 -> FETCH.
- ILLEGAL: illegal=1, all enables 0; stays in ILLEGAL until reset.
- Latency in cycles, mem_ready=1: ALU 4, LDR 5, STR 4, taken branch 3, BL 4, not-taken branch 2. Each wait cycle adds 1.
- Write-enable rules:
  - PCWrite is never high outside FETCH and BR_PC.
  - RegWrite and MemWrite are never high in the same cycle.
  - Flags changing after DECODE have no effect.

Test Plan:
- Reset held 3 cycles mid-MEM_WR with mem_ready=0 -> all outputs 0; FETCH on the first cycle after release; no MemWrite.
- ADD-immediate (cls=00, imm=1, func=010), mem_ready=1 -> states FETCH, DECODE, EXEC_I, ALU_WB; ALUControl=010 and ALUSrcB=01 in EXEC_I; RegWrite=1 for exactly 1 cycle.
- LDR with mem_ready low for 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles; RegWrite with ResultSrc=01 exactly once; total 7 cycles.
- BEQ: Z=1 -> BR_PC with PCWrite=1 (3 cycles); Z=0 -> DECODE goes to FETCH with no PCWrite beyond fetch; BNE (lnk=1) is the inverse.
- BL -> BR_LINK (RegWrite=1, RegSrc=111), then BR_PC (PCWrite=1, RegSrc=011); 4 cycles total.
- cls=01, sub=00 -> illegal=1 and sticky; FETCH never re-entered and PCWrite stays 0 until reset. With MEM_HANDSHAKE=0 and mem_ready tied 0, fetch still completes in 1 cycle.
